vga_scanout: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_scanout_if.sv | 23 ++
 rtl/vga_timing_gen.sv | 70 +++++++
 rtl/vga_scanout.sv | 127 ++++++++++++
 tb/tb_vga_scanout.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants, timing bundle type and porch/sync helpers
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Raw per-position timing flags; syncs are active low.
    typedef struct packed {
        logic act;
        logic hs_n;
        logic vs_n;
        logic fs;
    } timing_t;

    localparam timing_t TIMING_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

    function automatic int line_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    function automatic int sync_start(input int vis, input int front);
        return vis + front;
    endfunction

    function automatic int sync_end(input int vis, input int front, input int sync);
        return vis + front + sync - 1;
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - framebuffer read port plus video output bundle of the scanout
// master: scanout side (drives read_addr and video), slave: framebuffer/DAC side (drives read_data)
interface vga_scanout_if #(
    parameter int BITS_PER_PIXEL = 4
) ();
    logic [31:0]               read_addr;
    logic [BITS_PER_PIXEL-1:0] read_data;
    logic [BITS_PER_PIXEL-1:0] pixel;
    logic                      hsync;
    logic                      vsync;
    logic                      active;
    logic                      frame_start;

    modport master (
        output read_addr, pixel, hsync, vsync, active, frame_start,
        input  read_data
    );

    modport slave (
        input  read_addr, pixel, hsync, vsync, active, frame_start,
        output read_data
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - H/V position counters and raw act/hs_n/vs_n/fs flags
// ports: i_Clock, i_Reset_N (sync active-low), o_Timing (raw flags), o_Frame_Last (last visible pixel);
// with VGA_SCANOUT_PIXEL_DOUBLE_EN: o_Line_Last (last visible pixel of a line), o_Odd_Line (V bit 0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic    i_Clock,
    input  logic    i_Reset_N,
    output timing_t o_Timing,
`ifdef VGA_SCANOUT_PIXEL_DOUBLE_EN
    output logic    o_Line_Last,
    output logic    o_Odd_Line,
`endif
    output logic    o_Frame_Last
);
    localparam int H_TOTAL = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_LAST   = HW'(H_VISIBLE - 1);
    localparam logic [HW-1:0] HS_START = HW'(sync_start(H_VISIBLE, H_FRONT));
    localparam logic [HW-1:0] HS_END   = HW'(sync_end(H_VISIBLE, H_FRONT, H_SYNC));
    localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] VS_START = VW'(sync_start(V_VISIBLE, V_FRONT));
    localparam logic [VW-1:0] VS_END   = VW'(sync_end(V_VISIBLE, V_FRONT, V_SYNC));

    logic [HW-1:0] r_H;
    logic [VW-1:0] r_V;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_H <= '0;
            r_V <= '0;
        end else if (r_H == H_MAX) begin
            r_H <= '0;
            r_V <= (r_V == V_MAX) ? '0 : r_V + 1'b1;
        end else begin
            r_H <= r_H + 1'b1;
        end
    end

    always_comb begin
        o_Timing      = TIMING_IDLE;
        o_Timing.act  = (r_H < H_VIS) && (r_V < V_VIS);
        o_Timing.hs_n = !((r_H >= HS_START) && (r_H <= HS_END));
        o_Timing.vs_n = !((r_V >= VS_START) && (r_V <= VS_END));
        o_Timing.fs   = (r_H == '0) && (r_V == '0);
    end

    assign o_Frame_Last = (r_H == H_LAST) && (r_V == V_LAST);
`ifdef VGA_SCANOUT_PIXEL_DOUBLE_EN
    assign o_Line_Last  = (r_H == H_LAST) && (r_V < V_VIS);
    assign o_Odd_Line   = r_V[0];
`endif

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA scanout: framebuffer address generation, read-latency realignment, registered video outputs
// ports: i_Clock, i_Reset_N (sync active-low), o_Read_Addr/i_Read_Data (framebuffer sync read port),
// o_Pixel, o_HSync, o_VSync, o_Active, o_Frame_Start (all aligned, READ_LATENCY+1 cycles after the position)
// optional: VGA_SCANOUT_PIXEL_DOUBLE_EN shows a half-resolution framebuffer as 2x2 pixel blocks
module vga_scanout
    import vga_timing_pkg::*;
#(
    parameter int BITS_PER_PIXEL = 4,
    parameter int H_VISIBLE      = DEF_H_VISIBLE,
    parameter int H_FRONT        = DEF_H_FRONT,
    parameter int H_SYNC         = DEF_H_SYNC,
    parameter int H_BACK         = DEF_H_BACK,
    parameter int V_VISIBLE      = DEF_V_VISIBLE,
    parameter int V_FRONT        = DEF_V_FRONT,
    parameter int V_SYNC         = DEF_V_SYNC,
    parameter int V_BACK         = DEF_V_BACK,
    parameter int READ_LATENCY   = 1
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_N,
    output logic [31:0]               o_Read_Addr,
    input  logic [BITS_PER_PIXEL-1:0] i_Read_Data,
    output logic [BITS_PER_PIXEL-1:0] o_Pixel,
    output logic                      o_HSync,
    output logic                      o_VSync,
    output logic                      o_Active,
    output logic                      o_Frame_Start
);
    timing_t w_Timing;
    logic    w_Frame_Last;

    logic [31:0]               r_Addr;
    timing_t                   r_Dly [READ_LATENCY];
    logic [BITS_PER_PIXEL-1:0] r_Pixel;
    timing_t                   r_Out;

`ifdef VGA_SCANOUT_PIXEL_DOUBLE_EN
    logic        w_Line_Last;
    logic        w_Odd_Line;
    logic [31:0] r_Line_Base;
    logic [31:0] w_Next_Base;
`endif

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .i_Clock      (i_Clock),
        .i_Reset_N    (i_Reset_N),
        .o_Timing     (w_Timing),
`ifdef VGA_SCANOUT_PIXEL_DOUBLE_EN
        .o_Line_Last  (w_Line_Last),
        .o_Odd_Line   (w_Odd_Line),
`endif
        .o_Frame_Last (w_Frame_Last)
    );

    // The address register always holds the address of the current position's pixel,
    // so during blanking it already points at the first pixel of the next line.
`ifdef VGA_SCANOUT_PIXEL_DOUBLE_EN
    assign w_Next_Base = r_Line_Base + 32'(H_VISIBLE / 2);

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_Addr      <= '0;
            r_Line_Base <= '0;
        end else if (w_Frame_Last) begin
            r_Addr      <= '0;
            r_Line_Base <= '0;
        end else if (w_Line_Last) begin
            // Even display lines are shown twice: rewind to the same stored line,
            // odd lines move on to the next stored line.
            if (w_Odd_Line) begin
                r_Line_Base <= w_Next_Base;
                r_Addr      <= w_Next_Base;
            end else begin
                r_Addr      <= r_Line_Base;
            end
        end else if (w_Timing.act && u_timing.r_H[0]) begin
            r_Addr <= r_Addr + 32'd1;
        end
    end
`else
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_Addr <= '0;
        end else if (w_Frame_Last) begin
            r_Addr <= '0;
        end else if (w_Timing.act) begin
            r_Addr <= r_Addr + 32'd1;
        end
    end
`endif

    assign o_Read_Addr = r_Addr;

    // Timing flags ride a READ_LATENCY-deep delay line so they meet the returned data.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_Dly[i] <= TIMING_IDLE;
            end
            r_Out   <= TIMING_IDLE;
            r_Pixel <= '0;
        end else begin
            r_Dly[0] <= w_Timing;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_Dly[i] <= r_Dly[i-1];
            end
            r_Out   <= r_Dly[READ_LATENCY-1];
            r_Pixel <= r_Dly[READ_LATENCY-1].act ? i_Read_Data : '0;
        end
    end

    assign o_Pixel       = r_Pixel;
    assign o_HSync       = r_Out.hs_n;
    assign o_VSync       = r_Out.vs_n;
    assign o_Active      = r_Out.act;
    assign o_Frame_Start = r_Out.fs;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - self-checking bench: 640x480 RL=1 instance and small-geometry RL=3 instance against a position model
module tb_vga_scanout;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
    } geom_t;

    geom_t ga = '{640, 16, 96, 48, 480, 10, 2, 33};
    geom_t gb = '{8, 2, 3, 3, 6, 1, 2, 2};   // 16 x 11 -> 176-cycle frame

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic chk = 1'b0;
    int   k = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    vga_scanout_if #(.BITS_PER_PIXEL(4)) bus_a ();
    vga_scanout_if #(.BITS_PER_PIXEL(4)) bus_b ();

    vga_scanout #(
        .BITS_PER_PIXEL (4),
        .READ_LATENCY   (1)
    ) dut_a (
        .i_Clock       (clk),
        .i_Reset_N     (rstn),
        .o_Read_Addr   (bus_a.read_addr),
        .i_Read_Data   (bus_a.read_data),
        .o_Pixel       (bus_a.pixel),
        .o_HSync       (bus_a.hsync),
        .o_VSync       (bus_a.vsync),
        .o_Active      (bus_a.active),
        .o_Frame_Start (bus_a.frame_start)
    );

    vga_scanout #(
        .BITS_PER_PIXEL (4),
        .H_VISIBLE      (8),
        .H_FRONT        (2),
        .H_SYNC         (3),
        .H_BACK         (3),
        .V_VISIBLE      (6),
        .V_FRONT        (1),
        .V_SYNC         (2),
        .V_BACK         (2),
        .READ_LATENCY   (3)
    ) dut_b (
        .i_Clock       (clk),
        .i_Reset_N     (rstn),
        .o_Read_Addr   (bus_b.read_addr),
        .i_Read_Data   (bus_b.read_data),
        .o_Pixel       (bus_b.pixel),
        .o_HSync       (bus_b.hsync),
        .o_VSync       (bus_b.vsync),
        .o_Active      (bus_b.active),
        .o_Frame_Start (bus_b.frame_start)
    );

    // Framebuffer models: content at address A is A[3:0], returned after the read latency.
    logic [3:0] fb_a [1];
    logic [3:0] fb_b [3];

    always @(posedge clk) begin
        fb_a[0] <= bus_a.read_addr[3:0];
        fb_b[0] <= bus_b.read_addr[3:0];
        fb_b[1] <= fb_b[0];
        fb_b[2] <= fb_b[1];
    end

    assign bus_a.read_data = fb_a[0];
    assign bus_b.read_data = fb_b[2];

    // k = number of clock edges since reset was last sampled, i.e. the current scan position index.
    always @(posedge clk) begin
        if (!rstn) k <= 0;
        else       k <= k + 1;
    end

    // ---------------- model ----------------
    function automatic int htot(input geom_t g);
        return g.hv + g.hf + g.hs + g.hb;
    endfunction

    function automatic int vtot(input geom_t g);
        return g.vv + g.vf + g.vs + g.vb;
    endfunction

    function automatic void model_timing(input geom_t g, input int p,
                                         output logic act, output logic hs_n,
                                         output logic vs_n, output logic fs);
        int h, v;
        if (p < 0) begin
            act = 1'b0; hs_n = 1'b1; vs_n = 1'b1; fs = 1'b0;
            return;
        end
        h    = p % htot(g);
        v    = (p / htot(g)) % vtot(g);
        act  = (h < g.hv) && (v < g.vv);
        hs_n = !((h >= g.hv + g.hf) && (h < g.hv + g.hf + g.hs));
        vs_n = !((v >= g.vv + g.vf) && (v < g.vv + g.vf + g.vs));
        fs   = (h == 0) && (v == 0);
    endfunction

    // Framebuffer address shown at scan position p (next line's first pixel during blanking).
    function automatic int model_addr(input geom_t g, input int p);
        int h, v;
        h = p % htot(g);
        v = (p / htot(g)) % vtot(g);
`ifdef VGA_SCANOUT_PIXEL_DOUBLE_EN
        if (h < g.hv && v < g.vv) return (v / 2) * (g.hv / 2) + h / 2;
        if (v < g.vv - 1)         return ((v + 1) / 2) * (g.hv / 2);
        return 0;
`else
        if (h < g.hv && v < g.vv) return v * g.hv + h;
        if (v < g.vv - 1)         return (v + 1) * g.hv;
        return 0;
`endif
    endfunction

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s k=%0d got=%0d want=%0d", nm, k, got, want);
        end
    endtask

    task automatic check_dut(input string nm, input geom_t g, input int rl, input int kk,
                             input logic [31:0] ra, input logic [3:0] px, input logic hsy,
                             input logic vsy, input logic act, input logic fst);
        logic e_act, e_hs, e_vs, e_fs;
        int   p;
        p = kk - rl - 1;
        model_timing(g, p, e_act, e_hs, e_vs, e_fs);
        check({nm, ".read_addr"}, int'(ra), model_addr(g, kk));
        check({nm, ".pixel"}, int'(px), e_act ? (model_addr(g, p) % 16) : 0);
        check({nm, ".active"}, int'(act), int'(e_act));
        check({nm, ".hsync"}, int'(hsy), int'(e_hs));
        check({nm, ".vsync"}, int'(vsy), int'(e_vs));
        check({nm, ".frame_start"}, int'(fst), int'(e_fs));
    endtask

    // ---------------- trackers for hand-computed expectations ----------------
    int fa_a, hsl_a, fs_a_n, fs_a_k, addr_a_700, addr_a_800, addr_a_1600;
    int fa_b, fs_b_n, fs_b_k1, fs_b_k2, vs_low_b, hs_low_b, addr_b_87, addr_b_88;

    always @(negedge clk) begin
        if (chk) begin
            check_dut("a", ga, 1, k, bus_a.read_addr, bus_a.pixel, bus_a.hsync,
                      bus_a.vsync, bus_a.active, bus_a.frame_start);
            check_dut("b", gb, 3, k, bus_b.read_addr, bus_b.pixel, bus_b.hsync,
                      bus_b.vsync, bus_b.active, bus_b.frame_start);
            if (k == 0) begin
                fa_a = -1; hsl_a = -1; fs_a_n = 0; fs_a_k = -1;
                addr_a_700 = -1; addr_a_800 = -1; addr_a_1600 = -1;
                fa_b = -1; fs_b_n = 0; fs_b_k1 = -1; fs_b_k2 = -1;
                vs_low_b = 0; hs_low_b = 0; addr_b_87 = -1; addr_b_88 = -1;
            end else begin
                if (k >= 2 && k <= 641) begin
`ifdef VGA_SCANOUT_PIXEL_DOUBLE_EN
                    check("a.line0_pixel", int'(bus_a.pixel), ((k - 2) / 2) % 16);
`else
                    check("a.line0_pixel", int'(bus_a.pixel), (k - 2) % 16);
`endif
                end
                if (bus_a.active && fa_a < 0) fa_a = k;
                if (!bus_a.hsync && hsl_a < 0) hsl_a = k;
                if (bus_a.frame_start && k <= 1000) begin
                    fs_a_n++;
                    if (fs_a_k < 0) fs_a_k = k;
                end
                if (k == 700)  addr_a_700  = int'(bus_a.read_addr);
                if (k == 800)  addr_a_800  = int'(bus_a.read_addr);
                if (k == 1600) addr_a_1600 = int'(bus_a.read_addr);
                if (bus_b.active && fa_b < 0) fa_b = k;
                if (bus_b.frame_start && k <= 1000) begin
                    fs_b_n++;
                    if (fs_b_k1 < 0) fs_b_k1 = k;
                    else if (fs_b_k2 < 0) fs_b_k2 = k;
                end
                if (k >= 4 && k < 180 && !bus_b.vsync) vs_low_b++;
                if (k >= 4 && k < 20 && !bus_b.hsync) hs_low_b++;
                if (k == 87) addr_b_87 = int'(bus_b.read_addr);
                if (k == 88) addr_b_88 = int'(bus_b.read_addr);
            end
        end
    end

    task automatic wait_k(input int target);
        int n;
        n = 0;
        while (k < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_k_timeout", int'(k >= target), 1);
    endtask

    task automatic phase_checks();
        check("a.first_active_k", fa_a, 2);
        check("a.hsync_fall_after_active", hsl_a - fa_a, 656);
        check("a.frame_start_count", fs_a_n, 1);
        check("a.frame_start_k", fs_a_k, fa_a);
`ifdef VGA_SCANOUT_PIXEL_DOUBLE_EN
        check("a.addr_line0_blank", addr_a_700, 0);
        check("a.addr_line1_h0", addr_a_800, 0);
        check("a.addr_line2_h0", addr_a_1600, 320);
        check("b.addr_last_pixel", addr_b_87, 11);
`else
        check("a.addr_line0_blank", addr_a_700, 640);
        check("a.addr_line1_h0", addr_a_800, 640);
        check("a.addr_line2_h0", addr_a_1600, 1280);
        check("b.addr_last_pixel", addr_b_87, 47);
`endif
        check("b.addr_after_last", addr_b_88, 0);
        check("b.first_active_k", fa_b, 4);
        check("b.frame_start_count", fs_b_n, 6);
        check("b.frame_period", fs_b_k2 - fs_b_k1, 176);
        check("b.vsync_low_per_frame", vs_low_b, 32);
        check("b.hsync_low_per_line", hs_low_b, 3);
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk  = 1'b1;
        rstn = 1'b1;
        wait_k(1700);
        phase_checks();

        // Mid-frame reset: small instance at line 3, H=5.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((k % 176) != 53 && n < 400);
        check("mid_reset_position_reached", int'((k % 176) == 53), 1);
        rstn = 1'b0;
        @(negedge clk);
        check("b.reset_active", int'(bus_b.active), 0);
        check("b.reset_hsync", int'(bus_b.hsync), 1);
        check("b.reset_vsync", int'(bus_b.vsync), 1);
        check("b.reset_pixel", int'(bus_b.pixel), 0);
        check("b.reset_read_addr", int'(bus_b.read_addr), 0);
        check("a.reset_read_addr", int'(bus_a.read_addr), 0);
        check("a.reset_active", int'(bus_a.active), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_k(1700);
        phase_checks();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
